i2c_peripheral: RTL and testbench
=================================

# i2c_peripheral

Oversampled I2C target (peripheral) that answers a single 7-bit address on a shared SDA/SCL bus. It runs on the fast system clock, synchronizes and edge-detects SCL and SDA, and decodes START and STOP conditions. It ACKs its address, delivers written bytes to user logic and serves read bytes from user logic. It is the bus-side counterpart of `i2c_controller`, and the two are exercised against each other in loopback benches.

## Interface
- `ADDRESS`, default 7'h4D: 7-bit target address. Address byte 8'h9A selects a write; 8'h9B selects a read.
- `clk`  in  1  system clock. Must be ≥10× the SCL frequency (6 MHz against a 400 kHz SCL).
- `reset`  in  1  asynchronous, active-low reset.
- `scl`  in  1  bus clock, raw from pin.
- `sda_in`  in  1  bus data, raw from pin.
- `sda_out`  out  1  constant 0 (open-drain).
- `sda_oe`  out  1  1 = pull SDA low.
- `busy`  out  1  1 while addressed (from the address ACK until STOP, repeated START, or read NACK).
- `write_mode`  out  1  latched inverse of the R/W bit for the current transaction. 1 = controller writes.
- `received_data`  out  8  last byte written by the controller. Held until the next byte completes.
- `received_valid`  out  1  one-clk pulse when `received_data` updates.
- `transmit_data`  in  8  next byte to send on a read.
- `transmit_taken`  out  1  one-clk pulse in the cycle `transmit_data` is sampled. User logic presents the next byte before the following byte boundary.

## Operation
- **Input conditioning**
  - `scl` and `sda_in` each pass through a 2-flop synchronizer plus one history flop.
  - Edges are detected from the last two synchronized samples.
- **Bus conditions** (evaluated in every state)
  - START: SDA falls while SCL is high in both samples. Go to ADDR, clear the bit count, set `sda_oe`=0. A repeated START behaves the same way.
  - STOP: SDA rises while SCL is high. Go to IDLE and set `sda_oe`=0.
  - START and STOP take priority over the data-bit actions in the same cycle.
- **States**
  - IDLE: wait for START.
  - ADDR: shift SDA in MSB-first on each SCL rise. On the SCL fall after bit 8:
    - if the upper 7 bits equal `ADDRESS`, set `sda_oe`=1, latch `write_mode`, set `busy`=1, and go to ADDR_ACK;
    - otherwise go to IGNORE.
  - ADDR_ACK: hold SDA low through the ACK clock. On the next SCL fall:
    - for a write, release SDA and go to WRITE_BYTE;
    - for a read, load `transmit_data`, pulse `transmit_taken`, drive bit 7 (`sda_oe`=~bit), and go to READ_BYTE.
  - WRITE_BYTE: sample 8 bits on SCL rises. On the SCL fall after bit 8, update `received_data`, pulse `received_valid`, set `sda_oe`=1, and go to WRITE_ACK. Every byte is ACKed.
  - WRITE_ACK: on the SCL fall, release SDA and go to WRITE_BYTE.
  - READ_BYTE: on each SCL fall, drive the next bit. On the SCL fall after bit 8, release SDA and go to READ_ACK.
  - READ_ACK: sample SDA on the SCL rise.
    - ACK (0): on the SCL fall, load the next byte, pulse `transmit_taken`, drive bit 7, and go to READ_BYTE.
    - NACK (1): keep SDA released, clear `busy`, and go to IGNORE.
  - IGNORE: SDA released. Wait for STOP (go to IDLE) or START (go to ADDR).
- **Partial bytes:** a partial byte cut short by START or STOP is discarded. No `received_valid` pulse occurs for it.
- **Bit counter:** 3 bits. It wraps 7→0 at each byte boundary.

## Timing
- **Reset values:** `sda_oe`=0, `sda_out`=0, `busy`=0, `write_mode`=0, `received_data`=8'h00, `received_valid`=0, `transmit_taken`=0, state IDLE.
- **Reset mid-transfer:** asserting `reset` releases SDA immediately (asynchronously), including during an ACK.
- **Pin-to-detect latency:** 3 clk from a pin edge to its detected edge.
- **SDA update:** SDA changes in the clk after a detected SCL fall, i.e. 3–4 clk after the pin fall. It is therefore stable before SCL rises when clk ≥10× SCL.
- **`received_valid`:** asserted in the same clk as the ACK drive begins.
- **Bus-condition response:** `busy` falls, and `sda_oe` releases, within 4 clk of a STOP or START on the pins.

## Test plan
- **Reset:** hold `reset`=0 with bus toggling → all outputs at reset values. Assert `reset`=0 while `sda_oe`=1 → `sda_oe`=0 in the same cycle.
- **Write:** START, 8'h9A, 8'hAB, 8'h55, STOP → SDA pulled low on the 9th SCL of each of the three bytes. `received_valid` pulses twice, with `received_data` 8'hAB then 8'h55. `write_mode`=1. `busy` falls ≤4 clk after STOP.
- **Address mismatch:** START, 8'h9C, 8'h12, STOP → `sda_oe`=0 throughout, no `received_valid`, `busy`=0.
- **Read:** START, 8'h9B with `transmit_data`=8'hA5 then 8'h3C; controller ACKs the first byte and NACKs the second → SDA bits 1010_0101 then 0011_1100. `transmit_taken` pulses twice. `sda_oe`=0 after the NACK. `busy`=0 before STOP.
- **Repeated START:** START, 8'h9A, 4 bits of data, START, 8'h9B → partial byte discarded (no `received_valid`). New address ACKed. Read proceeds with `write_mode`=0.
- **Clock ratio:** SCL at 400 kHz with `clk` at 6 MHz, and SCL at 100 kHz → identical bit-level results; no setup violation on SDA relative to SCL rise.

Source files
------------

// File: rtl/i2c_peripheral.sv
// Oversampled I2C target answering a single 7-bit address.
// SCL/SDA are synchronized and edge-detected on the fast system clock; START/STOP are
// decoded in every state and pre-empt any data-bit action in the same cycle.
module i2c_peripheral #(
  parameter logic [6:0] ADDRESS = 7'h4D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oe,
  output logic       busy,
  output logic       write_mode,
  output logic [7:0] received_data,
  output logic       received_valid,
  input  logic [7:0] transmit_data,
  output logic       transmit_taken
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWriteByte,
    StWriteAck,
    StReadByte,
    StReadAck,
    StIgnore
  } state_e;

  // [0] meta flop, [1] synchronized sample, [2] history sample
  logic [2:0] scl_pipe_q;
  logic [2:0] sda_pipe_q;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  // Set once the eighth bit of a byte has been sampled (or a read ACK seen),
  // so the following SCL fall knows a byte boundary has been reached.
  logic       byte_done_q, byte_done_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       write_mode_q, write_mode_d;
  logic [7:0] received_data_q, received_data_d;
  logic       received_valid_q, received_valid_d;
  logic       transmit_taken_q, transmit_taken_d;

  logic scl_s, scl_h, sda_s, sda_h;
  logic scl_rise, scl_fall, scl_high;
  logic start_cond, stop_cond;

  assign scl_s = scl_pipe_q[1];
  assign scl_h = scl_pipe_q[2];
  assign sda_s = sda_pipe_q[1];
  assign sda_h = sda_pipe_q[2];

  assign scl_rise   = scl_s & ~scl_h;
  assign scl_fall   = ~scl_s & scl_h;
  assign scl_high   = scl_s & scl_h;
  assign start_cond = scl_high & ~sda_s & sda_h;
  assign stop_cond  = scl_high & sda_s & ~sda_h;

  // Input synchronizers; reset to the idle-high bus level so no edge is seen on release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_pipe_q <= 3'b111;
      sda_pipe_q <= 3'b111;
    end else begin
      scl_pipe_q <= {scl_pipe_q[1:0], scl};
      sda_pipe_q <= {sda_pipe_q[1:0], sda_in};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      bit_cnt_q        <= 3'd0;
      byte_done_q      <= 1'b0;
      rx_shift_q       <= 8'h00;
      tx_shift_q       <= 8'h00;
      sda_oe_q         <= 1'b0;
      busy_q           <= 1'b0;
      write_mode_q     <= 1'b0;
      received_data_q  <= 8'h00;
      received_valid_q <= 1'b0;
      transmit_taken_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      bit_cnt_q        <= bit_cnt_d;
      byte_done_q      <= byte_done_d;
      rx_shift_q       <= rx_shift_d;
      tx_shift_q       <= tx_shift_d;
      sda_oe_q         <= sda_oe_d;
      busy_q           <= busy_d;
      write_mode_q     <= write_mode_d;
      received_data_q  <= received_data_d;
      received_valid_q <= received_valid_d;
      transmit_taken_q <= transmit_taken_d;
    end
  end

  // Next-state logic: bus conditions first, then per-state bit handling.
  always_comb begin
    state_d          = state_q;
    bit_cnt_d        = bit_cnt_q;
    byte_done_d      = byte_done_q;
    rx_shift_d       = rx_shift_q;
    tx_shift_d       = tx_shift_q;
    sda_oe_d         = sda_oe_q;
    busy_d           = busy_q;
    write_mode_d     = write_mode_q;
    received_data_d  = received_data_q;
    received_valid_d = 1'b0;
    transmit_taken_d = 1'b0;

    if (start_cond) begin
      state_d     = StAddr;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else if (stop_cond) begin
      state_d     = StIdle;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          sda_oe_d = 1'b0;
        end

        StAddr: begin
          if (scl_rise) begin
            rx_shift_d = {rx_shift_q[6:0], sda_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            if (rx_shift_q[7:1] == ADDRESS) begin
              sda_oe_d     = 1'b1;
              write_mode_d = ~rx_shift_q[0];
              busy_d       = 1'b1;
              state_d      = StAddrAck;
            end else begin
              state_d = StIgnore;
            end
          end
        end

        StAddrAck: begin
          if (scl_fall) begin
            bit_cnt_d = 3'd0;
            if (write_mode_q) begin
              sda_oe_d = 1'b0;
              state_d  = StWriteByte;
            end else begin
              tx_shift_d       = transmit_data;
              transmit_taken_d = 1'b1;
              sda_oe_d         = ~transmit_data[7];
              state_d          = StReadByte;
            end
          end
        end

        StWriteByte: begin
          if (scl_rise) begin
            rx_shift_d = {rx_shift_q[6:0], sda_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall && byte_done_q) begin
            byte_done_d      = 1'b0;
            received_data_d  = rx_shift_q;
            received_valid_d = 1'b1;
            sda_oe_d         = 1'b1;
            state_d          = StWriteAck;
          end
        end

        StWriteAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = StWriteByte;
          end
        end

        StReadByte: begin
          // Bit 7 is already on the bus; each fall moves to the next bit.
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d    = 1'b0;
              byte_done_d = 1'b0;
              state_d     = StReadAck;
            end else begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              sda_oe_d   = ~tx_shift_q[6];
            end
          end
        end

        StReadAck: begin
          if (scl_rise) begin
            if (sda_s) begin
              busy_d   = 1'b0;
              sda_oe_d = 1'b0;
              state_d  = StIgnore;
            end else begin
              byte_done_d = 1'b1;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d      = 1'b0;
            bit_cnt_d        = 3'd0;
            tx_shift_d       = transmit_data;
            transmit_taken_d = 1'b1;
            sda_oe_d         = ~transmit_data[7];
            state_d          = StReadByte;
          end
        end

        StIgnore: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = StIdle;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_out        = 1'b0;
  assign sda_oe         = sda_oe_q;
  assign busy           = busy_q;
  assign write_mode     = write_mode_q;
  assign received_data  = received_data_q;
  assign received_valid = received_valid_q;
  assign transmit_taken = transmit_taken_q;

endmodule

// File: tb/tb_i2c_peripheral.sv
// Bench for i2c_peripheral: bit-banged I2C controller with an open-drain SDA model.
module tb_i2c_peripheral;

  logic       clk;
  logic       reset;
  logic       scl;
  logic       ctrl_low;
  logic       sda_line;
  logic       sda_out;
  logic       sda_oe;
  logic       busy;
  logic       write_mode;
  logic [7:0] received_data;
  logic       received_valid;
  logic [7:0] transmit_data;
  logic       transmit_taken;

  int checks;
  int errors;
  int low_cyc;
  int high_cyc;
  int rx_count;
  int taken_count;
  int oe_cycles;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] tx_feed[$];

  assign sda_line = ~(ctrl_low | sda_oe);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  i2c_peripheral #(.ADDRESS(7'h4D)) dut (
    .clk           (clk),
    .reset         (reset),
    .scl           (scl),
    .sda_in        (sda_line),
    .sda_out       (sda_out),
    .sda_oe        (sda_oe),
    .busy          (busy),
    .write_mode    (write_mode),
    .received_data (received_data),
    .received_valid(received_valid),
    .transmit_data (transmit_data),
    .transmit_taken(transmit_taken)
  );

  // Scoreboard for written bytes, plus the user-side transmit byte feeder.
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (sda_oe) oe_cycles++;
      if (received_valid) begin
        rx_count++;
        checks++;
        if (exp_rx.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected got %h", received_data);
        end else begin
          e = exp_rx.pop_front();
          if (received_data !== e) begin
            errors++;
            $display("FAIL rx_data got %h want %h", received_data, e);
          end
        end
      end
      if (transmit_taken) begin
        taken_count++;
        if (tx_feed.size() > 0) transmit_data = tx_feed.pop_front();
      end
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period; SDA set mid-low, sampled at rise and again before fall.
  task automatic bit_cycle(input logic b, output logic s);
    logic s2;
    wait_clk(low_cyc / 2);
    ctrl_low = ~b;
    wait_clk(low_cyc - low_cyc / 2);
    scl = 1'b1;
    s = sda_line;
    wait_clk(high_cyc);
    s2 = sda_line;
    checks++;
    if (s2 !== s) begin
      errors++;
      $display("FAIL sda_stable got %b want %b", s2, s);
    end
    scl = 1'b0;
  endtask

  task automatic start_cond();
    wait_clk(high_cyc);
    ctrl_low = 1'b1;
    wait_clk(high_cyc);
    scl = 1'b0;
  endtask

  task automatic rstart_cond();
    wait_clk(low_cyc / 2);
    ctrl_low = 1'b0;
    wait_clk(low_cyc - low_cyc / 2);
    scl = 1'b1;
    wait_clk(2);
    ctrl_low = 1'b1;
    wait_clk(4);
    checks++;
    if (busy !== 1'b0 || sda_oe !== 1'b0) begin
      errors++;
      $display("FAIL rstart_release got busy=%b oe=%b want 0 0", busy, sda_oe);
    end
    wait_clk((high_cyc > 6) ? high_cyc - 6 : 1);
    scl = 1'b0;
  endtask

  task automatic stop_cond();
    wait_clk(low_cyc / 2);
    ctrl_low = 1'b1;
    wait_clk(low_cyc - low_cyc / 2);
    scl = 1'b1;
    wait_clk(high_cyc / 2);
    ctrl_low = 1'b0;
    wait_clk(4);
    checks++;
    if (busy !== 1'b0 || sda_oe !== 1'b0) begin
      errors++;
      $display("FAIL stop_release got busy=%b oe=%b want 0 0", busy, sda_oe);
    end
    wait_clk(high_cyc);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(nack, s);
  endtask

  task automatic check_ack(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic check_rd(input logic [7:0] got);
    logic [7:0] e;
    checks++;
    if (exp_tx.size() == 0) begin
      errors++;
      $display("FAIL rd_unexpected got %h", got);
    end else begin
      e = exp_tx.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL rd_data got %h want %h", got, e);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      scl = 1'($urandom_range(0, 1));
      ctrl_low = 1'($urandom_range(0, 1));
      wait_clk(1);
    end
    scl = 1'b1;
    ctrl_low = 1'b0;
    wait_clk(2);
    checks++;
    if ({sda_oe, sda_out, busy, write_mode, received_valid, transmit_taken} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b%b%b%b%b%b want 000000", sda_oe, sda_out, busy,
               write_mode, received_valid, transmit_taken);
    end
    checks++;
    if (received_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %h want 00", received_data);
    end
    reset = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_write(input int lc, input int hc);
    logic ack;
    int rx0;
    low_cyc = lc;
    high_cyc = hc;
    rx0 = rx_count;
    exp_rx.push_back(8'hAB);
    exp_rx.push_back(8'h55);
    start_cond();
    send_byte(8'h9A, ack);
    check_ack("wr_addr_ack", ack, 1'b0);
    checks++;
    if (busy !== 1'b1 || write_mode !== 1'b1) begin
      errors++;
      $display("FAIL wr_mode got busy=%b wm=%b want 1 1", busy, write_mode);
    end
    send_byte(8'hAB, ack);
    check_ack("wr_data0_ack", ack, 1'b0);
    send_byte(8'h55, ack);
    check_ack("wr_data1_ack", ack, 1'b0);
    stop_cond();
    checks++;
    if (rx_count - rx0 != 2) begin
      errors++;
      $display("FAIL wr_valid_count got %0d want 2", rx_count - rx0);
    end
    checks++;
    if (received_data !== 8'h55) begin
      errors++;
      $display("FAIL wr_hold got %h want 55", received_data);
    end
  endtask

  task automatic test_mismatch();
    logic ack;
    int rx0;
    int oe0;
    rx0 = rx_count;
    oe0 = oe_cycles;
    start_cond();
    send_byte(8'h9C, ack);
    check_ack("mm_addr_nack", ack, 1'b1);
    send_byte(8'h12, ack);
    check_ack("mm_data_nack", ack, 1'b1);
    stop_cond();
    checks++;
    if (oe_cycles != oe0 || rx_count != rx0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mm_quiet got oe=%0d rx=%0d busy=%b want 0 0 0", oe_cycles - oe0,
               rx_count - rx0, busy);
    end
  endtask

  task automatic test_read(input int lc, input int hc);
    logic ack;
    logic [7:0] d;
    int t0;
    low_cyc = lc;
    high_cyc = hc;
    t0 = taken_count;
    transmit_data = 8'hA5;
    tx_feed.push_back(8'h3C);
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'h3C);
    start_cond();
    send_byte(8'h9B, ack);
    check_ack("rd_addr_ack", ack, 1'b0);
    checks++;
    if (busy !== 1'b1 || write_mode !== 1'b0) begin
      errors++;
      $display("FAIL rd_mode got busy=%b wm=%b want 1 0", busy, write_mode);
    end
    recv_byte(1'b0, d);
    check_rd(d);
    recv_byte(1'b1, d);
    check_rd(d);
    wait_clk(4);
    checks++;
    if (sda_oe !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_nack_release got oe=%b busy=%b want 0 0", sda_oe, busy);
    end
    checks++;
    if (taken_count - t0 != 2) begin
      errors++;
      $display("FAIL rd_taken_count got %0d want 2", taken_count - t0);
    end
    stop_cond();
  endtask

  task automatic test_repeated_start();
    logic ack;
    logic s;
    logic [7:0] d;
    int rx0;
    logic [3:0] part;
    low_cyc = 8;
    high_cyc = 7;
    rx0 = rx_count;
    part = 4'b1011;
    start_cond();
    send_byte(8'h9A, ack);
    check_ack("rs_wr_ack", ack, 1'b0);
    for (int i = 3; i >= 0; i--) bit_cycle(part[i], s);
    rstart_cond();
    transmit_data = 8'h5A;
    exp_tx.push_back(8'h5A);
    send_byte(8'h9B, ack);
    check_ack("rs_rd_ack", ack, 1'b0);
    checks++;
    if (write_mode !== 1'b0) begin
      errors++;
      $display("FAIL rs_write_mode got %b want 0", write_mode);
    end
    recv_byte(1'b1, d);
    check_rd(d);
    stop_cond();
    checks++;
    if (rx_count != rx0) begin
      errors++;
      $display("FAIL rs_partial got %0d valid pulses want 0", rx_count - rx0);
    end
  endtask

  task automatic test_reset_mid_ack();
    logic s;
    logic [7:0] a;
    low_cyc = 8;
    high_cyc = 7;
    a = 8'h9A;
    start_cond();
    for (int i = 7; i >= 0; i--) bit_cycle(a[i], s);
    wait_clk(low_cyc / 2);
    ctrl_low = 1'b0;
    wait_clk(low_cyc - low_cyc / 2);
    scl = 1'b1;
    wait_clk(2);
    checks++;
    if (sda_oe !== 1'b1) begin
      errors++;
      $display("FAIL ack_drive got %b want 1", sda_oe);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (sda_oe !== 1'b0 || sda_line !== 1'b1) begin
      errors++;
      $display("FAIL async_release got oe=%b sda=%b want 0 1", sda_oe, sda_line);
    end
    wait_clk(3);
    reset = 1'b1;
    wait_clk(5);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rx_count = 0;
    taken_count = 0;
    oe_cycles = 0;
    low_cyc = 8;
    high_cyc = 7;
    reset = 1'b0;
    scl = 1'b1;
    ctrl_low = 1'b0;
    transmit_data = 8'h00;
    fork
      monitor();
    join_none
    test_reset();
    test_write(8, 7);
    test_mismatch();
    test_read(8, 7);
    test_repeated_start();
    test_write(30, 30);
    test_read(30, 30);
    test_reset_mid_ack();
    checks++;
    if (exp_rx.size() != 0 || exp_tx.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got rx=%0d tx=%0d want 0 0", exp_rx.size(),
               exp_tx.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
